clk_freq_monitor: RTL and testbench
===================================

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of monitored channels (1..16).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32: width of counter inputs and measured values.
REQ-003 SHALL have parameter REF_ROLLOVER, default 12500000: clk_ref cycles per measurement window (>=4).
REQ-004 SHALL have parameter FAIL_COUNT, default 2: consecutive out-of-range windows before a channel is declared stopped (1..15).
REQ-005 SHALL have parameter PASS_COUNT, default 3: consecutive in-range windows before a stopped channel is released (1..15).
REQ-006 SHALL have port clk_ref input 1: the single clock; one clock, all logic on rising edge.
REQ-007 SHALL have port reset_in input 1: reset, synchronous and active-high.
REQ-008 SHALL have port cnt_in input NUM_CH x COUNTER_WIDTH: free-running per-channel test-clock counters, already in clk_ref domain.
REQ-009 SHALL have ports min_count, max_count input NUM_CH x COUNTER_WIDTH: inclusive per-channel limits, quasi-static.
REQ-010 SHALL have port value output NUM_CH x COUNTER_WIDTH: last measured count per channel.
REQ-011 SHALL have port value_valid output 1: one-cycle pulse when value updates.
REQ-012 SHALL have ports too_slow, too_fast output NUM_CH: raw result of the latest window.
REQ-013 SHALL have port stopped output NUM_CH: debounced fault per channel.
REQ-014 SHALL have ports sticky_err output NUM_CH and sticky_clr input NUM_CH (see Configuration).

Function
REQ-015 SHALL run a window counter 0..REF_ROLLOVER-1, wrapping to 0; measure asserts while counter == REF_ROLLOVER-1.
REQ-016 On measure, SHALL latch snap[i] <= cnt_in[i] and compute delta = cnt_in[i] - snap[i] modulo 2^COUNTER_WIDTH (counter wrap yields correct delta).
REQ-017 SHALL discard the first measure after reset (prime only: snap loads, value/value_valid unchanged).
REQ-018 From the second measure on, value SHALL update and value_valid SHALL pulse exactly one cycle after measure.
REQ-019 too_slow[i] = value<min_count[i], too_fast[i] = value>max_count[i], registered one cycle after value_valid; equality with a limit is in range.
REQ-020 Per channel, an FSM SHALL have states OK, SUSPECT, STOPPED, RECOVER with a 4-bit run counter, evaluated on the same cycle as too_slow/too_fast.
REQ-021 OK: bad window -> run=1, SUSPECT (or STOPPED directly if FAIL_COUNT==1); good stays OK.
REQ-022 SUSPECT: bad increments run, entering STOPPED when run reaches FAIL_COUNT; good -> OK, run=0.
REQ-023 STOPPED: good -> run=1, RECOVER (or OK directly if PASS_COUNT==1); bad stays.
REQ-024 RECOVER: good increments run, entering OK at PASS_COUNT; bad -> STOPPED, run=0.
REQ-025 stopped[i] SHALL be 1 exactly in STOPPED and RECOVER.
REQ-026 Outputs not recomputed between windows SHALL hold their values.

Reset
REQ-027 While reset_in=1: window counter 0, all FSMs OK, run 0, value 0, value_valid/too_slow/too_fast/stopped/sticky_err 0, prime pending.
REQ-028 Reset asserted mid-window SHALL abandon the window; the first measure after release is a prime (REQ-017).

Configuration
REQ-029 With macro CLK_FREQ_MONITOR_STICKY_EN defined: sticky_err[i] sets when too_slow[i]|too_fast[i] is registered as 1, clears on sticky_clr[i]; simultaneous set and clear -> set wins.
REQ-030 Without CLK_FREQ_MONITOR_STICKY_EN: sticky_err tied 0, sticky_clr ignored, no sticky flops.

Structure
REQ-031 Package clk_freq_monitor_pkg SHALL hold the FSM state enum (OK, SUSPECT, STOPPED, RECOVER) and run-counter width constant.
REQ-032 Per-channel compare, FSM and sticky logic SHALL be sub-module clk_freq_chan, generated NUM_CH times; window counter and measure are shared in the top.

Verification (NUM_CH=2, COUNTER_WIDTH=16, REF_ROLLOVER=100, min=38, max=42, FAIL_COUNT=2, PASS_COUNT=3)
REQ-033 Ch0 +2/5 cycles, ch1 +1/2 cycles -> first measure no pulse; thereafter value={40,50}, too_fast[1]=1, stopped[1] after 2nd bad window.
REQ-034 cnt_in[0] start at 16'hFFF0, +2/5 cycles -> value[0]=40 across wrap, no fault.
REQ-035 Ch0 held constant 2 windows then resumed -> value 0, too_slow=1, stopped after 2nd window, released after 3 good windows.
REQ-036 Ch0 alternates value 40/0 each window -> SUSPECT/OK toggles, stopped never asserts.
REQ-037 reset_in pulsed at window cycle 50 -> all outputs 0 next cycle, next measure is a prime (no value_valid).
REQ-038 STICKY_EN: one bad window on ch0 -> sticky_err[0]=1 persists; sticky_clr[0] same cycle as new error -> stays 1; clr alone -> 0.

Source files
------------

// File: rtl/clk_freq_monitor_pkg.sv
// Shared types for the clock frequency monitor.
// Per-channel health FSM states and run-counter width.
package clk_freq_monitor_pkg;

  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    OK,
    SUSPECT,
    STOPPED,
    RECOVER
  } chan_state_e;

endpackage

// File: rtl/clk_freq_monitor_if.sv
// Bus bundle between the frequency monitor and its host.
// Counter inputs, limits, measured values and per-channel flags.
interface clk_freq_monitor_if #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 32
);

  logic [NUM_CH*COUNTER_WIDTH-1:0] cnt_in;
  logic [NUM_CH*COUNTER_WIDTH-1:0] min_count;
  logic [NUM_CH*COUNTER_WIDTH-1:0] max_count;
  logic [NUM_CH*COUNTER_WIDTH-1:0] value;
  logic                            value_valid;
  logic [NUM_CH-1:0]               too_slow;
  logic [NUM_CH-1:0]               too_fast;
  logic [NUM_CH-1:0]               stopped;
  logic [NUM_CH-1:0]               sticky_err;
  logic [NUM_CH-1:0]               sticky_clr;

  modport master (
    output cnt_in, min_count, max_count, sticky_clr,
    input  value, value_valid, too_slow, too_fast,
    input  stopped, sticky_err
  );

  modport slave (
    input  cnt_in, min_count, max_count, sticky_clr,
    output value, value_valid, too_slow, too_fast,
    output stopped, sticky_err
  );

endinterface

// File: rtl/clk_freq_monitor_chan.sv
// One channel: limit compare, debounce FSM, optional sticky flag.
// Sticky flag exists only with CLK_FREQ_MONITOR_STICKY_EN defined.
module clk_freq_chan
  import clk_freq_monitor_pkg::*;
#(
  parameter int CW         = 32,
  parameter int FAIL_COUNT = 2,
  parameter int PASS_COUNT = 3
) (
  input  logic          clk_ref,
  input  logic          reset_in,
  input  logic          value_valid,
  input  logic [CW-1:0] value,
  input  logic [CW-1:0] min_count,
  input  logic [CW-1:0] max_count,
  input  logic          sticky_clr,
  output logic          too_slow,
  output logic          too_fast,
  output logic          stopped,
  output logic          sticky_err
);

  chan_state_e      state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;
  logic             slow_q, slow_d;
  logic             fast_q, fast_d;
  logic             is_slow, is_fast, bad;

  assign is_slow = value < min_count;
  assign is_fast = value > max_count;
  assign bad     = is_slow | is_fast;
  assign run_inc = run_q + 1'b1;

  // Next-state: flags and FSM only move on a fresh measurement
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    slow_d  = slow_q;
    fast_d  = fast_q;
    if (value_valid) begin
      slow_d = is_slow;
      fast_d = is_fast;
      unique case (state_q)
        OK: begin
          if (bad) begin
            if (FAIL_COUNT == 1) begin
              state_d = STOPPED;
              run_d   = '0;
            end else begin
              state_d = SUSPECT;
              run_d   = RUN_W'(1);
            end
          end
        end
        SUSPECT: begin
          if (!bad) begin
            state_d = OK;
            run_d   = '0;
          end else if (run_inc >= RUN_W'(FAIL_COUNT)) begin
            state_d = STOPPED;
            run_d   = '0;
          end else begin
            run_d   = run_inc;
          end
        end
        STOPPED: begin
          if (!bad) begin
            if (PASS_COUNT == 1) begin
              state_d = OK;
              run_d   = '0;
            end else begin
              state_d = RECOVER;
              run_d   = RUN_W'(1);
            end
          end
        end
        RECOVER: begin
          if (bad) begin
            state_d = STOPPED;
            run_d   = '0;
          end else if (run_inc >= RUN_W'(PASS_COUNT)) begin
            state_d = OK;
            run_d   = '0;
          end else begin
            run_d   = run_inc;
          end
        end
        default: begin
          state_d = OK;
          run_d   = '0;
        end
      endcase
    end
  end

  // State, run counter and raw flag registers
  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      state_q <= OK;
      run_q   <= '0;
      slow_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      slow_q  <= slow_d;
      fast_q  <= fast_d;
    end
  end

  assign too_slow = slow_q;
  assign too_fast = fast_q;
  assign stopped  = (state_q == STOPPED) | (state_q == RECOVER);

`ifdef CLK_FREQ_MONITOR_STICKY_EN
  logic sticky_q, sticky_d;

  // A new error wins over a same-cycle clear
  always_comb begin
    sticky_d = (value_valid & bad) | (sticky_q & ~sticky_clr);
  end

  // Sticky error register
  always_ff @(posedge clk_ref) begin
    if (reset_in) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign sticky_err = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = sticky_clr;
  assign sticky_err = 1'b0;
`endif

endmodule

// File: rtl/clk_freq_monitor.sv
// Multi-channel clock frequency monitor: shared window, per-channel checks.
// Optional sticky error flags: define CLK_FREQ_MONITOR_STICKY_EN.
module clk_freq_monitor
  import clk_freq_monitor_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int REF_ROLLOVER  = 12500000,
  parameter int FAIL_COUNT    = 2,
  parameter int PASS_COUNT    = 3
) (
  input logic          clk_ref,
  input logic          reset_in,
  clk_freq_monitor_if.slave bus
);

  localparam int CW = COUNTER_WIDTH;
  localparam int WW = (REF_ROLLOVER > 1) ? $clog2(REF_ROLLOVER) : 1;

  logic [WW-1:0]        win_q, win_d;
  logic [NUM_CH*CW-1:0] snap_q, snap_d;
  logic [NUM_CH*CW-1:0] value_q, value_d;
  logic                 vv_q, vv_d;
  logic                 primed_q, primed_d;
  logic                 measure;
  logic [NUM_CH-1:0]    slow_w, fast_w, stop_w, sticky_w;

  assign measure = (win_q == WW'(REF_ROLLOVER - 1));

  // Window counter and snapshot/delta; first measure only primes
  always_comb begin
    win_d    = measure ? '0 : win_q + 1'b1;
    snap_d   = snap_q;
    value_d  = value_q;
    vv_d     = 1'b0;
    primed_d = primed_q;
    if (measure) begin
      snap_d   = bus.cnt_in;
      primed_d = 1'b1;
      if (primed_q) begin
        vv_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          value_d[i*CW +: CW] = bus.cnt_in[i*CW +: CW]
                              - snap_q[i*CW +: CW];
        end
      end
    end
  end

  // Shared measurement registers
  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      win_q    <= '0;
      snap_q   <= '0;
      value_q  <= '0;
      vv_q     <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      snap_q   <= snap_d;
      value_q  <= value_d;
      vv_q     <= vv_d;
      primed_q <= primed_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_freq_chan #(
      .CW         (CW),
      .FAIL_COUNT (FAIL_COUNT),
      .PASS_COUNT (PASS_COUNT)
    ) u_chan (
      .clk_ref     (clk_ref),
      .reset_in    (reset_in),
      .value_valid (vv_q),
      .value       (value_q[g*CW +: CW]),
      .min_count   (bus.min_count[g*CW +: CW]),
      .max_count   (bus.max_count[g*CW +: CW]),
      .sticky_clr  (bus.sticky_clr[g]),
      .too_slow    (slow_w[g]),
      .too_fast    (fast_w[g]),
      .stopped     (stop_w[g]),
      .sticky_err  (sticky_w[g])
    );
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.too_slow    = slow_w;
  assign bus.too_fast    = fast_w;
  assign bus.stopped     = stop_w;
  assign bus.sticky_err  = sticky_w;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor (2 ch, 16-bit, 100-cycle window).
// Expected windows are queued by each scenario and checked on value_valid.
module tb_clk_freq_monitor;

  localparam int NCH = 2;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset_in = 1'b1;

  always #5 clk = ~clk;

  clk_freq_monitor_if #(.NUM_CH(NCH), .COUNTER_WIDTH(CW)) bus ();

  clk_freq_monitor #(
    .NUM_CH        (NCH),
    .COUNTER_WIDTH (CW),
    .REF_ROLLOVER  (100),
    .FAIL_COUNT    (2),
    .PASS_COUNT    (3)
  ) dut (
    .clk_ref  (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  typedef struct {
    logic [15:0] v0;
    logic [15:0] v1;
    logic [1:0]  ts;
    logic [1:0]  tf;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pend = 0;
  bit   prev_vv = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] c0 = '0, c1 = '0;
  int amt0 = 0, per0 = 5, amt1 = 0, per1 = 5;
  int ph = 0;

  function automatic exp_t mk(input int v0, input int v1,
                              input logic [1:0] ts, input logic [1:0] tf,
                              input logic [1:0] st);
    exp_t e;
    e.v0 = 16'(v0);
    e.v1 = 16'(v1);
    e.ts = ts;
    e.tf = tf;
    e.st = st;
    return e;
  endfunction

  // Advance the test counters for this cycle, then wait one clock
  task automatic tick();
    ph++;
    if (ph % per0 == 0) c0 = c0 + 16'(amt0);
    if (ph % per1 == 0) c1 = c1 + 16'(amt1);
    bus.cnt_in = {c1, c0};
    @(negedge clk);
  endtask

  task automatic wait_vv();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.value_valid && n < 250);
    if (!bus.value_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_vv: no value_valid after %0d cycles", n);
    end
  endtask

  task automatic start(input int a0, input int p0,
                       input int a1, input int p1);
    reset_in = 1'b1;
    amt0 = a0; per0 = p0;
    amt1 = a1; per1 = p1;
    repeat (3) tick();
    reset_in = 1'b0;
  endtask

  // Scoreboard: pop on value_valid, check flags one cycle later
  always @(negedge clk) begin
    if (reset_in) begin
      pend    = 0;
      prev_vv = 0;
    end else begin
      if (pend) begin
        pend = 0;
        vectors++;
        if ({bus.too_slow, bus.too_fast, bus.stopped}
            !== {cur.ts, cur.tf, cur.st}) begin
          miscompares++;
          $display("FAIL flags: got ts=%b tf=%b st=%b want ts=%b tf=%b st=%b",
                   bus.too_slow, bus.too_fast, bus.stopped,
                   cur.ts, cur.tf, cur.st);
        end
      end
      if (bus.value_valid) begin
        vectors++;
        if (prev_vv) begin
          miscompares++;
          $display("FAIL vv_width: value_valid high two cycles");
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL vv_unexpected: value=%h with nothing expected",
                   bus.value);
        end else begin
          cur = exp_q.pop_front();
          pend = 1;
          if (bus.value !== {cur.v1, cur.v0}) begin
            miscompares++;
            $display("FAIL value: got %h want %h", bus.value,
                     {cur.v1, cur.v0});
          end
        end
      end
      prev_vv = bus.value_valid;
    end
  end

  task automatic test_reset();
    bus.min_count  = {16'd38, 16'd38};
    bus.max_count  = {16'd42, 16'd42};
    bus.sticky_clr = '0;
    start(2, 5, 1, 2);
    reset_in = 1'b1;
    repeat (2) tick();
    vectors++;
    if (bus.value !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_value: got %h want 0", bus.value);
    end
    vectors++;
    if (bus.value_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vv: got %b want 0", bus.value_valid);
    end
    vectors++;
    if ({bus.too_slow, bus.too_fast} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.too_slow, bus.too_fast});
    end
    vectors++;
    if ({bus.stopped, bus.sticky_err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_stop: got %b want 0000",
               {bus.stopped, bus.sticky_err});
    end
  endtask

  task automatic test_basic();
    int n = 0;
    start(2, 5, 1, 2);
    exp_q.push_back(mk(40, 50, 2'b00, 2'b10, 2'b00));
    exp_q.push_back(mk(40, 50, 2'b00, 2'b10, 2'b10));
    exp_q.push_back(mk(40, 50, 2'b00, 2'b10, 2'b10));
    do begin
      tick();
      n++;
    end while (!bus.value_valid && n < 300);
    vectors++;
    if (n != 200) begin
      miscompares++;
      $display("FAIL basic_latency: first pulse at %0d want 200", n);
    end
    wait_vv();
    wait_vv();
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL basic_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    start(2, 5, 2, 5);
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    repeat (95) tick();
    c0 = 16'hFFF0;
    wait_vv();
    wait_vv();
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL wrap_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_hold();
    logic [1:0] want_sticky;
    start(2, 5, 2, 5);
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    exp_q.push_back(mk(0, 40, 2'b01, 2'b00, 2'b00));
    exp_q.push_back(mk(0, 40, 2'b01, 2'b00, 2'b01));
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    wait_vv();
    amt0 = 0;
    wait_vv();
    wait_vv();
    amt0 = 2;
    repeat (3) wait_vv();
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL hold_drain: %0d left want 0", exp_q.size());
    end
`ifdef CLK_FREQ_MONITOR_STICKY_EN
    want_sticky = 2'b01;
`else
    want_sticky = 2'b00;
`endif
    vectors++;
    if (bus.sticky_err !== want_sticky) begin
      miscompares++;
      $display("FAIL hold_sticky: got %b want %b",
               bus.sticky_err, want_sticky);
    end
  endtask

  task automatic test_alternate();
    start(2, 5, 2, 5);
    for (int w = 1; w <= 5; w++) begin
      if (w % 2 == 1) exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
      else            exp_q.push_back(mk(0, 40, 2'b01, 2'b00, 2'b00));
    end
    for (int w = 1; w <= 5; w++) begin
      wait_vv();
      amt0 = (w % 2 == 1) ? 0 : 2;
    end
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL alt_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_midreset();
    int n = 0;
    start(2, 5, 1, 2);
    exp_q.push_back(mk(40, 50, 2'b00, 2'b10, 2'b00));
    wait_vv();
    repeat (49) tick();
    reset_in = 1'b1;
    tick();
    vectors++;
    if ({bus.value, bus.value_valid} !== 33'h0) begin
      miscompares++;
      $display("FAIL midrst_value: got %h/%b want 0/0",
               bus.value, bus.value_valid);
    end
    vectors++;
    if ({bus.too_slow, bus.too_fast, bus.stopped, bus.sticky_err}
        !== 8'h0) begin
      miscompares++;
      $display("FAIL midrst_flags: got %b want 0",
               {bus.too_slow, bus.too_fast, bus.stopped, bus.sticky_err});
    end
    reset_in = 1'b0;
    exp_q.push_back(mk(40, 50, 2'b00, 2'b10, 2'b00));
    do begin
      tick();
      n++;
    end while (!bus.value_valid && n < 300);
    vectors++;
    if (n != 200) begin
      miscompares++;
      $display("FAIL midrst_prime: first pulse at %0d want 200", n);
    end
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL midrst_drain: %0d left want 0", exp_q.size());
    end
  endtask

`ifdef CLK_FREQ_MONITOR_STICKY_EN
  task automatic test_sticky();
    start(2, 5, 2, 5);
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    exp_q.push_back(mk(0, 40, 2'b01, 2'b00, 2'b00));
    exp_q.push_back(mk(40, 40, 2'b00, 2'b00, 2'b00));
    exp_q.push_back(mk(0, 40, 2'b01, 2'b00, 2'b00));
    wait_vv();
    amt0 = 0;
    wait_vv();
    amt0 = 2;
    tick();
    vectors++;
    if (bus.sticky_err !== 2'b01) begin
      miscompares++;
      $display("FAIL sticky_set: got %b want 01", bus.sticky_err);
    end
    wait_vv();
    amt0 = 0;
    tick();
    vectors++;
    if (bus.sticky_err !== 2'b01) begin
      miscompares++;
      $display("FAIL sticky_hold: got %b want 01", bus.sticky_err);
    end
    wait_vv();
    amt0 = 2;
    bus.sticky_clr = 2'b01;
    tick();
    bus.sticky_clr = 2'b00;
    vectors++;
    if (bus.sticky_err !== 2'b01) begin
      miscompares++;
      $display("FAIL sticky_setwins: got %b want 01", bus.sticky_err);
    end
    bus.sticky_clr = 2'b01;
    tick();
    bus.sticky_clr = 2'b00;
    vectors++;
    if (bus.sticky_err !== 2'b00) begin
      miscompares++;
      $display("FAIL sticky_clr: got %b want 00", bus.sticky_err);
    end
    repeat (2) tick();
    vectors++;
    if (exp_q.size() != 0 || pend) begin
      miscompares++;
      $display("FAIL sticky_drain: %0d left want 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    bus.cnt_in     = '0;
    bus.min_count  = '0;
    bus.max_count  = '0;
    bus.sticky_clr = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_alternate();
    test_midreset();
`ifdef CLK_FREQ_MONITOR_STICKY_EN
    test_sticky();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
